// File: rtl/temp_entry_pkg.sv
// temp_entry_pkg: scancodes, FSM state encoding and BCD helper shared by the temperature entry block
package temp_entry_pkg;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE = 2'd1;
  localparam logic [1:0] S_TWO = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;
  // tens*10 + units using shifts only
  function automatic logic [6:0] bcd2bin(input logic [3:0] t, input logic [3:0] u);
    return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, u};
  endfunction
endpackage

// File: rtl/scan_to_digit.sv
// scan_to_digit: decodes a PS/2 set-2 make code into a decimal digit
module scan_to_digit
  import temp_entry_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output logic [3:0] digit
);
  always_comb begin
    is_digit = 1'b1;
    digit = 4'd0;
    case (code)
      SC_D0: digit = 4'd0;
      SC_D1: digit = 4'd1;
      SC_D2: digit = 4'd2;
      SC_D3: digit = 4'd3;
      SC_D4: digit = 4'd4;
      SC_D5: digit = 4'd5;
      SC_D6: digit = 4'd6;
      SC_D7: digit = 4'd7;
      SC_D8: digit = 4'd8;
      SC_D9: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end
endmodule

// File: rtl/temp_entry_ctrl.sv
// temp_entry_ctrl: assembles two-digit temperature entries from PS/2 scancodes
// and hands them downstream over valid/ready, gating the receiver while one is pending.
module temp_entry_ctrl
  import temp_entry_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int TW = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  output logic       rx_en,
  output logic       entry_valid,
  input  logic       entry_ready,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] value,
  output logic       busy,
  output logic       err
);
  logic [1:0] state, nxt;
  logic brk, ext, brk_n, ext_n, err_n, is_digit, acc, expire, partial;
  logic [3:0] tens_n, units_n, dig;
  logic [6:0] value_n;
  logic [TW-1:0] cnt;
  scan_to_digit u_dec (.code(dout), .is_digit(is_digit), .digit(dig));
  assign acc = rx_done_tick & rx_en;
  assign partial = (state == S_ONE) || (state == S_TWO);
  assign expire = partial && (cnt == TW'(TIMEOUT_CYC - 1));
  always_comb begin
    nxt = state;
    tens_n = tens;
    units_n = units;
    value_n = value;
    brk_n = brk;
    ext_n = ext;
    err_n = 1'b0;
    if (state == S_OUT) begin
      if (entry_ready) begin
        nxt = S_EMPTY;
        tens_n = 4'd0;
        units_n = 4'd0;
        value_n = 7'd0;
      end
    end else if (acc) begin
      if (dout == SC_BRK) brk_n = 1'b1;
      else if (dout == SC_EXT) ext_n = 1'b1;
      else begin
        brk_n = 1'b0;
        ext_n = 1'b0;
        // a break code swallows whatever follows; an E0 prefix only passes keypad Enter
        if (!brk && dout == SC_ENTER) begin
          if (state == S_TWO) begin
            nxt = S_OUT;
            value_n = bcd2bin(tens, units);
          end else begin
            nxt = S_EMPTY;
            tens_n = 4'd0;
            units_n = 4'd0;
            err_n = 1'b1;
          end
        end else if (!brk && !ext && is_digit) begin
          if (state == S_EMPTY) begin
            nxt = S_ONE;
            tens_n = dig;
          end else if (state == S_ONE) begin
            nxt = S_TWO;
            units_n = dig;
          end else err_n = 1'b1;
        end else if (!brk && !ext && dout == SC_BKSP) begin
          if (state == S_TWO) begin
            nxt = S_ONE;
            units_n = 4'd0;
          end else if (state == S_ONE) begin
            nxt = S_EMPTY;
            tens_n = 4'd0;
          end
        end
      end
    end else if (expire) begin
      nxt = S_EMPTY;
      tens_n = 4'd0;
      units_n = 4'd0;
    end
    if (nxt == S_EMPTY && state != S_EMPTY) begin
      brk_n = 1'b0;
      ext_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_EMPTY;
      brk <= 1'b0;
      ext <= 1'b0;
      cnt <= '0;
      rx_en <= 1'b0;
      entry_valid <= 1'b0;
      tens <= 4'd0;
      units <= 4'd0;
      value <= 7'd0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      brk <= brk_n;
      ext <= ext_n;
      cnt <= (acc || expire || !partial) ? '0 : cnt + 1'b1;
      rx_en <= nxt != S_OUT;
      entry_valid <= nxt == S_OUT;
      tens <= tens_n;
      units <= units_n;
      value <= value_n;
      busy <= (nxt == S_ONE) || (nxt == S_TWO);
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_temp_entry_ctrl.sv
// tb_temp_entry_ctrl: directed checks of entry assembly, handshake, errors, timeout and reset
module tb_temp_entry_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_done_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic entry_ready = 1'b0;
  logic rx_en, entry_valid, busy, err;
  logic [3:0] tens, units;
  logic [6:0] value;
  int total = 0;
  int passed = 0;
  temp_entry_ctrl #(.TIMEOUT_CYC(100), .TW(7)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout), .rx_en(rx_en),
    .entry_valid(entry_valid), .entry_ready(entry_ready), .tens(tens), .units(units),
    .value(value), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick(input logic [7:0] c);
    @(negedge clk);
    rx_done_tick = 1'b1;
    dout = c;
    @(negedge clk);
    rx_done_tick = 1'b0;
    dout = 8'h00;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_en"}, rx_en, 0);
    chk({tag, "_valid"}, entry_valid, 0);
    chk({tag, "_tens"}, tens, 0);
    chk({tag, "_units"}, units, 0);
    chk({tag, "_value"}, value, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rx_en", rx_en, 1);
    // 26 with ready already high: valid lasts one cycle
    tick(8'h1E);
    chk("t1_busy", busy, 1);
    chk("t1_tens", tens, 2);
    tick(8'h36);
    chk("t1_units", units, 6);
    entry_ready = 1'b1;
    tick(8'h5A);
    chk("t1_valid", entry_valid, 1);
    chk("t1_value", value, 26);
    chk("t1_rx_en_low", rx_en, 0);
    chk("t1_busy_out", busy, 0);
    @(negedge clk);
    chk("t1_valid_drop", entry_valid, 0);
    chk("t1_rx_en_back", rx_en, 1);
    chk("t1_value_clr", value, 0);
    entry_ready = 1'b0;
    // 30 with break codes and keypad Enter, ready held low
    tick(8'h26);
    tick(8'hF0);
    tick(8'h26);
    chk("t2_brk_drop", busy, 1);
    tick(8'h45);
    tick(8'hF0);
    tick(8'h45);
    tick(8'hE0);
    tick(8'h5A);
    chk("t2_valid", entry_valid, 1);
    chk("t2_value", value, 30);
    tick(8'h16);
    repeat (8) @(negedge clk);
    chk("t2_hold_valid", entry_valid, 1);
    chk("t2_hold_value", value, 30);
    chk("t2_hold_tens", tens, 3);
    chk("t2_hold_units", units, 0);
    chk("t2_hold_rx_en", rx_en, 0);
    entry_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept", entry_valid, 0);
    chk("t2_rx_en", rx_en, 1);
    chk("t2_busy", busy, 0);
    chk("t2_tens_clr", tens, 0);
    entry_ready = 1'b0;
    // third digit error, backspace, then 17
    tick(8'h16);
    tick(8'h16);
    chk("t3_no_err", err, 0);
    tick(8'h16);
    chk("t3_err", err, 1);
    chk("t3_units", units, 1);
    @(negedge clk);
    chk("t3_err_pulse", err, 0);
    tick(8'h66);
    chk("t3_bksp", units, 0);
    chk("t3_bksp_busy", busy, 1);
    tick(8'h3D);
    tick(8'h5A);
    chk("t3_valid", entry_valid, 1);
    chk("t3_value", value, 17);
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    chk("t3_accept", entry_valid, 0);
    // early Enter errors, E0-prefixed digit discarded
    tick(8'h5A);
    chk("t4_err_empty", err, 1);
    chk("t4_no_valid", entry_valid, 0);
    tick(8'h16);
    chk("t4_tens", tens, 1);
    tick(8'hE0);
    tick(8'h1E);
    chk("t4_ext_units", units, 0);
    chk("t4_ext_busy", busy, 1);
    tick(8'h5A);
    chk("t4_err_one", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_tens_clr", tens, 0);
    chk("t4_no_valid2", entry_valid, 0);
    // timeout after 100 idle cycles
    tick(8'h25);
    repeat (99) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    @(negedge clk);
    chk("t5_timeout", busy, 0);
    chk("t5_no_err", err, 0);
    chk("t5_tens_clr", tens, 0);
    // tick landing on the expiry cycle wins
    tick(8'h25);
    repeat (98) @(negedge clk);
    tick(8'h3E);
    chk("t6_busy", busy, 1);
    chk("t6_units", units, 8);
    chk("t6_tens", tens, 4);
    chk("t6_no_err", err, 0);
    // reset while in S_TWO
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_two");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_two_rx_en", rx_en, 1);
    // 99 then reset while presented
    tick(8'h46);
    tick(8'h46);
    tick(8'h5A);
    chk("t7_value", value, 99);
    chk("t7_valid", entry_valid, 1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_out");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_rx_en", rx_en, 1);
    chk("rst_out_valid", entry_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/temp_entry_ctrl.md
# temp_entry_ctrl

- Sequences the PS/2 receiver: owns its `rx_en`, consumes its scancode stream and assembles two-digit decimal temperature entries (00–99).
- Handles break (F0) and extended (E0) prefixes, Backspace, Enter and an inactivity timeout.
- Delivers each committed entry over a valid/ready handshake to the temperature decoder/FSM side.
- Holds the keyboard off while an entry is waiting to be taken.

## Interface
Parameters:
- `TIMEOUT_CYC`, 100_000_000: idle cycles (1 s at 100 MHz) after which a partial entry is discarded.
- `TW`, 27: timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  reset; synchronous, active-low.
- `rx_done_tick`  in  1  one-cycle pulse from the PS/2 receiver: a scancode is valid on `dout`.
- `dout`  in  8  scancode from the PS/2 receiver.
- `rx_en`  out  1  receive enable to the PS/2 receiver.
- `entry_valid`  out  1  a committed entry is presented.
- `entry_ready`  in  1  downstream accepts the entry.
- `tens`  out  4  BCD tens digit.
- `units`  out  4  BCD units digit.
- `value`  out  7  binary value, tens*10+units.
- `busy`  out  1  a partial entry is held.
- `err`  out  1  one-cycle pulse on an entry error.

## Operation
- States:
  - `S_EMPTY`: no digits held.
  - `S_ONE`: tens digit held.
  - `S_TWO`: tens and units held.
  - `S_OUT`: entry presented.
- A tick is accepted only when `rx_done_tick`=1 and `rx_en`=1. Ticks while `rx_en`=0 are ignored.
- Prefix flags `brk` and `ext` are cleared on reset and on every transition into `S_EMPTY`.
- Accepted code 0xF0 sets `brk`. Accepted code 0xE0 sets `ext`.
- Non-prefix code with `brk`=1: discarded; clears `brk` and `ext`.
- Non-prefix code with `ext`=1, `brk`=0:
  - 0x5A (keypad Enter) is treated as Enter.
  - Any other code is discarded.
  - `ext` is cleared in both cases.
- Digit make codes: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9. Typematic repeats count as new digits.
- Transitions:
  - `S_EMPTY` + digit d → `S_ONE`, `tens`←d.
  - `S_ONE` + digit d → `S_TWO`, `units`←d.
  - `S_TWO` + digit → stay in `S_TWO`, digit dropped, `err` pulse.
  - Enter (0x5A) in `S_TWO` → `S_OUT`, `value` registered.
  - Enter in `S_EMPTY` or `S_ONE` → `S_EMPTY`, digits cleared to 0, `err` pulse.
  - Backspace (0x66): `S_TWO`→`S_ONE` with `units`←0; `S_ONE`→`S_EMPTY` with `tens`←0; `S_EMPTY` no-op.
  - Any other code: ignored.
  - `S_OUT` with `entry_ready`=1 → `S_EMPTY`, digits and `value` cleared.
- Timeout: the counter runs only in `S_ONE`/`S_TWO` and clears on every accepted tick. On reaching `TIMEOUT_CYC`-1 the block returns to `S_EMPTY` with digits cleared and no `err`.
- Simultaneous tick and timeout expiry: the tick wins, is processed normally and clears the counter.
- Reset mid-entry or mid-handshake: everything returns to reset values at the next edge; an entry not yet accepted is lost.

## Timing
- All outputs are registered.
- Reset values: `rx_en`=0, `entry_valid`=0, `tens`=0, `units`=0, `value`=0, `busy`=0, `err`=0.
- `rx_en` is 1 from the first cycle after reset release in every state except `S_OUT`. It drops in the same edge that enters `S_OUT`.
- Latency: a tick at edge n changes state/outputs at edge n+1. `entry_valid` rises the cycle after the Enter tick.
- Handshake:
  - `entry_valid`, `tens`, `units`, `value` hold stable until the edge where `entry_valid`&`entry_ready`=1.
  - `entry_valid` falls the next cycle; `rx_en` rises the same cycle.
  - `entry_ready` is ignored while `entry_valid`=0.
- `busy`=1 exactly in `S_ONE`/`S_TWO`.
- `err` is high for exactly one cycle per error event.
- `value` arithmetic: (tens<<3)+(tens<<1)+units, 7 bits, maximum 99; no overflow is possible.

## Structure
- Shared package `temp_entry_pkg` holds:
  - scancode constants: F0, E0, 5A, 66 and the ten digit codes;
  - the state enumeration (2-bit encoding).
- One combinational sub-module, `scan_to_digit`: 8-bit code in → `is_digit`, 4-bit digit out.
- FSM, prefix flags, timeout counter and output registers live in `temp_entry_ctrl`.

## Test plan
- Ticks 0x1E, 0x36, 0x5A, `entry_ready`=1 → one `entry_valid` cycle with `tens`=2, `units`=6, `value`=26; `rx_en`=0 while valid; `rx_en`=1 after acceptance.
- Sequence 0x26, F0 26, 0x45, F0 45, E0 5A with `entry_ready` held 0 for 10 cycles:
  - `value`=30 held stable;
  - a `rx_done_tick` during `S_OUT` is ignored;
  - handshake completes when `entry_ready` goes 1.
- 0x16, 0x16, 0x16 → `err` pulse on the third digit. Then 0x66, 0x3D, 0x5A → `value`=17.
- 0x5A in `S_EMPTY` → `err` pulse, no `entry_valid`. 0x16 then 0x5A → `err` pulse, return to `S_EMPTY`.
- `TIMEOUT_CYC`=100:
  - 0x25, then idle for 100 cycles → `busy` falls with no `err`;
  - repeat with a tick landing on the expiry cycle → tick is processed, no timeout.
- Reset asserted (0) while in `S_TWO` and while in `S_OUT` → all outputs at reset values at the next edge; `rx_en`=1 one cycle after release.
